ripl_cary_add_pipe: RTL

RIPL_CARY_ADD_PIPE -- requirements
Module: ripl_cary_add_pipe

---
 rtl/rca_pkg.sv | 16 +
 rtl/rca_seg.sv | 27 ++
 rtl/ripl_cary_add_pipe.sv | 132 +++++++++++++
 3 files changed

// File: rtl/rca_pkg.sv
// Shared defaults and stage-count derivation for the pipelined ripple-carry adder.
package rca_pkg;

   localparam int unsigned DefWidth  = 16;
   localparam int unsigned DefSeg    = 4;
   localparam int unsigned DefStages = DefWidth / DefSeg;

   // Clamped to 1 so arrays stay legal while the elaboration check reports a bad config.
   function automatic int unsigned calc_stages(input int unsigned width, input int unsigned seg);
      if (seg == 0 || width < seg) begin
         return 1;
      end
      return width / seg;
   endfunction

endpackage

// File: rtl/rca_seg.sv
// SEG-bit combinational ripple full-adder chain used by each pipeline stage.
module rca_seg
   import rca_pkg::*;
#(
   parameter int unsigned SEG = DefSeg
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           ci,
   output logic [SEG-1:0] s,
   output logic           co
);

   logic [SEG:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int i = 0; i < SEG; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      co = c[SEG];
   end

endmodule

// File: rtl/ripl_cary_add_pipe.sv
// Pipelined ripple-carry adder, SEG bits per stage, valid/ready handshake on both ends.
// Optional subtract support is enabled by defining RCA_SUB_EN.
module ripl_cary_add_pipe
   import rca_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned SEG   = DefSeg
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
`ifdef RCA_SUB_EN
   input  logic             Sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             Ovf
);

   localparam int unsigned STAGES = calc_stages(WIDTH, SEG);
   localparam int unsigned LAST   = STAGES - 1;

   if (SEG < 1) begin : g_bad_seg
      $error("ripl_cary_add_pipe: SEG must be at least 1");
   end else if (WIDTH % SEG != 0) begin : g_bad_width
      $error("ripl_cary_add_pipe: WIDTH must be a multiple of SEG");
   end

   // Per-stage registers; operands ride along full width so the MSBs reach the Ovf logic.
   logic [STAGES-1:0] vld_q;
   logic [STAGES-1:0] cy_q;
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  s_q [STAGES];

   logic [STAGES-1:0] v_in;
   logic [STAGES-1:0] ci_in;
   logic [WIDTH-1:0]  a_in  [STAGES];
   logic [WIDTH-1:0]  b_in  [STAGES];
   logic [WIDTH-1:0]  s_in  [STAGES];
   logic [WIDTH-1:0]  s_nxt [STAGES];
   logic [WIDTH-1:0]  seg_sum;
   logic [STAGES-1:0] seg_co;

   logic             stall;
   logic             advance;
   logic             accept;
   logic [WIDTH-1:0] b_eff;
   logic             c_eff;

   assign stall    = vld_q[LAST] && !out_ready;
   assign advance  = en && !stall;
   assign in_ready = rst_n && advance;
   assign accept   = in_valid && in_ready;

   always_comb begin
`ifdef RCA_SUB_EN
      b_eff = Sub ? ~B : B;
      c_eff = Sub | Cin;
`else
      b_eff = B;
      c_eff = Cin;
`endif
      v_in     = '0;
      ci_in    = '0;
      v_in[0]  = accept;
      ci_in[0] = c_eff;
      a_in[0]  = A;
      b_in[0]  = b_eff;
      s_in[0]  = '0;
      for (int k = 1; k < STAGES; k++) begin
         v_in[k]  = vld_q[k-1];
         ci_in[k] = cy_q[k-1];
         a_in[k]  = a_q[k-1];
         b_in[k]  = b_q[k-1];
         s_in[k]  = s_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         s_nxt[k]                 = s_in[k];
         s_nxt[k][k*SEG +: SEG]   = seg_sum[k*SEG +: SEG];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      rca_seg #(
         .SEG (SEG)
      ) u_seg (
         .a  (a_in[k][k*SEG +: SEG]),
         .b  (b_in[k][k*SEG +: SEG]),
         .ci (ci_in[k]),
         .s  (seg_sum[k*SEG +: SEG]),
         .co (seg_co[k])
      );
   end

   // Whole pipeline moves in lockstep; a stall or en=0 freezes every stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         cy_q  <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
      end else if (advance) begin
         vld_q <= v_in;
         cy_q  <= seg_co;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= a_in[k];
            b_q[k] <= b_in[k];
            s_q[k] <= s_nxt[k];
         end
      end
   end

   always_comb begin
      out_valid = en && vld_q[LAST];
      S         = en ? s_q[LAST] : '0;
      Cout      = en && cy_q[LAST];
      Ovf       = en && (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1])
                     && (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
   end

endmodule
